// File: rtl/signal_pulse_gen.sv
// signal_pulse_gen: raw pushbutton -> synchroniser -> debouncer -> one-clock step pulses.
// Optional auto-repeat while the button stays held is compiled in when the macro
// SIGNAL_AUTO_REPEAT_EN is defined; otherwise each accepted press gives exactly one pulse.
module signal_pulse_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 2400000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       signal,
    output logic       btn_level,
    output logic [2:0] pulse_count
);

    // One shared counter, sized for the longest interval it ever has to reach.
    localparam int unsigned MaxDbRd   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                          : REPEAT_DELAY;
    localparam int unsigned MaxCycles = (MaxDbRd > REPEAT_PERIOD) ? MaxDbRd : REPEAT_PERIOD;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef SIGNAL_AUTO_REPEAT_EN
    localparam logic [CntW-1:0] RpDelayLast  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RpPeriodLast = CntW'(REPEAT_PERIOD - 1);
`endif

    // Raw (un-normalised) idle level of the pin, loaded into the synchroniser on reset.
    localparam logic [SYNC_STAGES-1:0] SyncIdle = {SYNC_STAGES{BTN_ACTIVE_LOW}};

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StPressDb   = 3'd1,
        StHeld      = 3'd2,
        StReleaseDb = 3'd3
`ifdef SIGNAL_AUTO_REPEAT_EN
        ,
        StRepeat    = 3'd4
`endif
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   signal_q, signal_d;
    logic                   level_q, level_d;
    logic [2:0]             pulse_cnt_q, pulse_cnt_d;
    logic                   pressed_s;

    // Shift the raw pin through the metastability chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    assign pressed_s = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

    // Debounce / repeat FSM, counter and pulse bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        signal_d    = 1'b0;
        level_d     = level_q;
        pulse_cnt_d = pulse_cnt_q + {2'b00, signal_q};

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pressed_s) begin
                    state_d = StPressDb;
                end
            end
            StPressDb: begin
                // Release is checked first so a bounce on the final cycle still loses.
                if (!pressed_s) begin
                    state_d = StIdle;
                end else if (cnt_q == DbLast) begin
                    state_d  = StHeld;
                    level_d  = 1'b1;
                    signal_d = 1'b1;
                end
            end
            StHeld: begin
                if (!pressed_s) begin
                    state_d = StReleaseDb;
`ifdef SIGNAL_AUTO_REPEAT_EN
                end else if (cnt_q == RpDelayLast) begin
                    state_d  = StRepeat;
                    signal_d = 1'b1;
                end
`else
                end else begin
                    cnt_d = '0;
                end
`endif
            end
`ifdef SIGNAL_AUTO_REPEAT_EN
            StRepeat: begin
                if (!pressed_s) begin
                    state_d = StReleaseDb;
                end else if (cnt_q == RpPeriodLast) begin
                    signal_d = 1'b1;
                    cnt_d    = '0;
                end
            end
`endif
            StReleaseDb: begin
                if (pressed_s) begin
                    state_d = StHeld;
                end else if (cnt_q == DbLast) begin
                    state_d = StIdle;
                    level_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= SyncIdle;
            state_q     <= StIdle;
            cnt_q       <= '0;
            signal_q    <= 1'b0;
            level_q     <= 1'b0;
            pulse_cnt_q <= 3'd0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            signal_q    <= signal_d;
            level_q     <= level_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign signal      = signal_q;
    assign btn_level   = level_q;
    assign pulse_count = pulse_cnt_q;

endmodule

// File: tb/tb_signal_pulse_gen.sv
// Bench for signal_pulse_gen: behavioural run-length model checked every cycle, plus
// literal pulse-timing expectations for the directed scenarios and a random bounce phase.
module tb_signal_pulse_gen;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned Db         = 4;
    localparam int unsigned Rd         = 10;
    localparam int unsigned Rp         = 5;
`ifdef SIGNAL_AUTO_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_raw = 1'b1;
    logic       signal;
    logic       btn_level;
    logic [2:0] pulse_count;

    signal_pulse_gen #(
        .SYNC_STAGES    (SyncStages),
        .DEBOUNCE_CYCLES(Db),
        .REPEAT_DELAY   (Rd),
        .REPEAT_PERIOD  (Rp),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .signal     (signal),
        .btn_level  (btn_level),
        .pulse_count(pulse_count)
    );

    initial forever #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // ---------------- behavioural model ----------------
    // p = pressed level seen SyncStages edges late. Level flips after Db+1 consecutive
    // disagreeing samples; while held, repeats land at Rd, Rd+Rp, ... edges after hold start.
    bit m_sig   = 1'b0;
    bit m_lvl   = 1'b0;
    int m_cnt   = 0;
    int run     = 0;
    int t_held  = 0;
    bit held_ok = 1'b0;
    bit hist [SyncStages];

    function automatic void model_reset();
        for (int i = 0; i < SyncStages; i++) hist[i] = 1'b0;
        m_sig   = 1'b0;
        m_lvl   = 1'b0;
        m_cnt   = 0;
        run     = 0;
        t_held  = 0;
        held_ok = 1'b0;
    endfunction

    function automatic void model_step(input bit raw);
        bit p;
        m_cnt = (m_cnt + (m_sig ? 1 : 0)) % 8;
        p = hist[SyncStages-1];
        for (int i = SyncStages - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = (raw == 1'b0);
        m_sig = 1'b0;
        if (p != m_lvl) begin
            run++;
            held_ok = 1'b0;
            if (run == int'(Db) + 1) begin
                m_lvl = p;
                run   = 0;
                if (p) begin
                    m_sig   = 1'b1;
                    held_ok = 1'b1;
                    t_held  = 0;
                end
            end
        end else begin
            run = 0;
            if (m_lvl) begin
                if (!held_ok) begin
                    held_ok = 1'b1;
                    t_held  = 0;
                end else begin
                    t_held++;
                    if (RepeatEn && t_held >= int'(Rd) && (t_held - int'(Rd)) % int'(Rp) == 0)
                        m_sig = 1'b1;
                end
            end
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step(btn_raw);
        end
    end

    // ---------------- edge counter and event recorder ----------------
    int edge_n = 0;
    int base   = 0;
    int pulses [$];
    int rises  [$];
    int falls  [$];
    bit lvl_prev = 1'b0;
    bit sig_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    // Per-cycle compare against the model, plus event capture for literal checks.
    initial forever begin
        @(negedge clk);
        check("signal", int'(signal), int'(m_sig));
        check("btn_level", int'(btn_level), int'(m_lvl));
        check("pulse_count", int'(pulse_count), m_cnt);
        if (signal === 1'b1) begin
            check("no_back_to_back", int'(sig_prev), 0);
            pulses.push_back(edge_n - base - 1);
        end
        if (btn_level === 1'b1 && !lvl_prev) rises.push_back(edge_n - base - 1);
        if (btn_level === 1'b0 && lvl_prev) falls.push_back(edge_n - base - 1);
        lvl_prev = (btn_level === 1'b1);
        sig_prev = (signal === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_test();
        pulses.delete();
        rises.delete();
        falls.delete();
        base = edge_n;
    endtask

    task automatic drive(input logic v, input int n);
        btn_raw = v;
        repeat (n) @(negedge clk);
    endtask

    // Assert reset mid-cycle, confirm outputs clear without a clock edge, hold two cycles.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_signal"}, int'(signal), 0);
        check({tag, "_level"}, int'(btn_level), 0);
        check({tag, "_count"}, int'(pulse_count), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic check_pulses(input string name, input int exp_q [$]);
        check({name, "_n"}, pulses.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < pulses.size()) check({name, "_at"}, pulses[i], exp_q[i]);
            else check({name, "_missing"}, -1, exp_q[i]);
        end
    endtask

    initial begin
        int exp_q [$];
        // 1. reset state
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_signal", int'(signal), 0);
        check("rst_level", int'(btn_level), 0);
        check("rst_count", int'(pulse_count), 0);
        #2 reset = 1'b0;
        drive(1'b1, 5);

        // 2. single clean press
        start_test();
        drive(1'b0, 8);
        drive(1'b1, 12);
        exp_q = '{6};
        check_pulses("press", exp_q);
        check("press_rise", (rises.size() > 0) ? rises[0] : -1, 6);
        check("press_fall", (falls.size() > 0) ? falls[0] : -1, 14);
        check("press_count", int'(pulse_count), 1);
        check("model_count", m_cnt, 1);

        // 3. bounce shorter than debounce
        start_test();
        drive(1'b0, 3);
        drive(1'b1, 12);
        check("bounce_pulses", pulses.size(), 0);
        check("bounce_rises", rises.size(), 0);
        check("bounce_count", int'(pulse_count), 1);

        // 4. nine clean presses, pulse_count wraps
        @(negedge clk);
        pulse_reset("rst4");
        start_test();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 8);
            drive(1'b1, 12);
            check("nine_count", int'(pulse_count), (i + 1) % 8);
            exp_q.push_back(6 + 20 * i);
        end
        check_pulses("nine", exp_q);

        // 5. long hold
        pulse_reset("rst5");
        drive(1'b1, 4);
        start_test();
        drive(1'b0, 30);
        drive(1'b1, 12);
        if (RepeatEn) exp_q = '{6, 16, 21, 26, 31};
        else exp_q = '{6};
        check_pulses("hold", exp_q);
        check("hold_count", int'(pulse_count), RepeatEn ? 5 : 1);

        // 6. reset while held, button still down afterwards
        pulse_reset("rst6a");
        drive(1'b1, 4);
        start_test();
        drive(1'b0, 19);
        check("held_level", int'(btn_level), 1);
        check("held_count", int'(pulse_count), RepeatEn ? 2 : 1);
        pulse_reset("rst6");
        start_test();
        drive(1'b0, 12);
        drive(1'b1, 12);
        exp_q = '{6};
        check_pulses("after_rst", exp_q);
        check("after_rst_count", int'(pulse_count), 1);

        // 7. random bounces, long holds and occasional resets
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                pulse_reset("rst_rand");
            end else if ($urandom_range(0, 3) == 0) begin
                drive(1'($urandom_range(0, 1)), $urandom_range(5, 40));
            end else begin
                drive(1'($urandom_range(0, 1)), $urandom_range(1, 7));
            end
        end
        drive(1'b1, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
